// File: rtl/rsa_seq_pkg.sv
// rsa_seq_pkg: state encodings, error codes and status bit positions for the RSA DMA sequencer
package rsa_seq_pkg;
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RX_REQ    = 4'd1,
        S_RX_WAIT   = 4'd2,
        S_CORE_GO   = 4'd3,
        S_CORE_WAIT = 4'd4,
        S_TX_REQ    = 4'd5,
        S_TX_WAIT   = 4'd6,
        S_DONE      = 4'd7,
        S_ERR       = 4'd8
    } state_t;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DMA  = 2'd1;
    localparam logic [1:0] ERR_DTMO = 2'd2;
    localparam logic [1:0] ERR_CTMO = 2'd3;
    localparam int ST_DONE  = 0;
    localparam int ST_IDLE  = 1;
    localparam int ST_ERR   = 2;
    localparam int ST_CODE  = 3;
    localparam int ST_STATE = 8;
endpackage

// File: rtl/rsa_seq_timer.sv
// rsa_seq_timer: wait-state cycle counter; trips once limit cycles elapse, disabled when limit is 0
module rsa_seq_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         trip
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    // cnt holds cycles already spent, so the limit-th wait cycle trips
    assign trip = en && (limit != '0) && (cnt >= limit - 1'b1);
endmodule

// File: rtl/rsa_dma_seq.sv
// rsa_dma_seq: fetches NUM_RX operands over DMA, runs the exponentiation core, writes the result back
module rsa_dma_seq
    import rsa_seq_pkg::*;
#(
    parameter int NUM_RX = 5,
    parameter int TMO_W  = 24
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 go,
    input  logic                 abort,
    input  logic [NUM_RX*32-1:0] rx_addr,
    input  logic [31:0]          tx_addr,
    input  logic [TMO_W-1:0]     tmo_cycles,
    output logic [31:0]          dma_rx_address,
    output logic [31:0]          dma_tx_address,
    output logic                 dma_rx_start,
    output logic                 dma_tx_start,
    input  logic                 dma_done,
    input  logic                 dma_idle,
    input  logic                 dma_error,
    output logic [NUM_RX-1:0]    load_en,
    output logic                 core_start,
    input  logic                 core_done,
    output logic                 res_load,
    output logic [31:0]          status
);
    localparam int IW = NUM_RX > 1 ? $clog2(NUM_RX) : 1;
    state_t state, nxt;
    logic [IW-1:0] idx, idx_n;
    logic [1:0] code, code_n;
    logic [31:0] rx_sel;
    logic trip;
    rsa_seq_timer #(.W(TMO_W)) u_timer (
        .clk   (clk),
        .resetn(resetn),
        .clr   (nxt != state),
        .en    (state inside {S_RX_WAIT, S_CORE_WAIT, S_TX_WAIT}),
        .limit (tmo_cycles),
        .trip  (trip)
    );
    always_comb begin
        nxt = state;
        idx_n = idx;
        code_n = code;
        case (state)
            S_IDLE: if (go) begin
                nxt = S_RX_REQ;
                idx_n = '0;
                code_n = ERR_NONE;
            end
            S_RX_REQ: nxt = dma_error ? S_ERR : !dma_idle ? S_RX_WAIT : S_RX_REQ;
            S_RX_WAIT:
                if (dma_error) nxt = S_ERR;
                else if (dma_done) begin
                    nxt = (idx == IW'(NUM_RX - 1)) ? S_CORE_GO : S_RX_REQ;
                    idx_n = (idx == IW'(NUM_RX - 1)) ? idx : idx + 1'b1;
                end else if (trip) begin
                    nxt = S_ERR;
                    code_n = ERR_DTMO;
                end
            S_CORE_GO: nxt = S_CORE_WAIT;
            S_CORE_WAIT:
                if (core_done) nxt = S_TX_REQ;
                else if (trip) begin
                    nxt = S_ERR;
                    code_n = ERR_CTMO;
                end
            S_TX_REQ: nxt = dma_error ? S_ERR : !dma_idle ? S_TX_WAIT : S_TX_REQ;
            S_TX_WAIT:
                if (dma_error) nxt = S_ERR;
                else if (dma_done) nxt = S_DONE;
                else if (trip) begin
                    nxt = S_ERR;
                    code_n = ERR_DTMO;
                end
            S_DONE, S_ERR: nxt = go ? state : S_IDLE;
            default: nxt = S_IDLE;
        endcase
        // DMA errors share one code regardless of which DMA state saw them
        if (dma_error && (state inside {S_RX_REQ, S_RX_WAIT, S_TX_REQ, S_TX_WAIT})) code_n = ERR_DMA;
        if (abort) begin
            nxt = S_IDLE;
            code_n = ERR_NONE;
        end
    end
    always_comb begin
        rx_sel = '0;
        for (int i = 0; i < NUM_RX; i++)
            if (idx_n == IW'(i)) rx_sel = rx_addr[i*32 +: 32];
    end
    always_comb begin
        load_en = '0;
        for (int i = 0; i < NUM_RX; i++)
            load_en[i] = (state == S_RX_WAIT) && (idx == IW'(i));
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state <= S_IDLE;
            idx <= '0;
            code <= ERR_NONE;
            dma_rx_address <= '0;
            dma_tx_address <= '0;
            dma_rx_start <= 1'b0;
            dma_tx_start <= 1'b0;
        end else begin
            state <= nxt;
            idx <= idx_n;
            code <= code_n;
            dma_rx_start <= nxt == S_RX_REQ;
            dma_tx_start <= nxt == S_TX_REQ;
            if (nxt == S_RX_REQ && state != S_RX_REQ) dma_rx_address <= rx_sel;
            if (nxt == S_TX_REQ && state != S_TX_REQ) dma_tx_address <= tx_addr;
        end
    assign core_start = state == S_CORE_GO;
    assign res_load = (state == S_CORE_WAIT) && core_done && !abort;
    always_comb begin
        status = '0;
        status[ST_STATE +: 4] = state;
        status[ST_CODE +: 2] = code;
        status[ST_ERR] = state == S_ERR;
        status[ST_IDLE] = state == S_IDLE;
        status[ST_DONE] = state == S_DONE;
    end
endmodule

// File: tb/tb_rsa_dma_seq.sv
// tb_rsa_dma_seq: drives random RSA jobs through the sequencer and checks handshakes against the job rules
module tb_rsa_dma_seq;
    localparam int N = 5;
    localparam int TW = 24;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic go = 1'b0;
    logic abort = 1'b0;
    logic [N*32-1:0] rx_addr = '0;
    logic [31:0] tx_addr = '0;
    logic [TW-1:0] tmo_cycles = '0;
    logic dma_done = 1'b0;
    logic dma_idle = 1'b1;
    logic dma_error = 1'b0;
    logic core_done = 1'b0;
    logic [31:0] dma_rx_address, dma_tx_address, status;
    logic dma_rx_start, dma_tx_start, core_start, res_load;
    logic [N-1:0] load_en;
    logic [31:0] slot [N];
    int total = 0;
    int bad = 0;
    int n_cs = 0, n_rl = 0, n_txs = 0, n_le3 = 0;

    rsa_dma_seq #(.NUM_RX(N), .TMO_W(TW)) dut (
        .clk(clk), .resetn(resetn), .go(go), .abort(abort),
        .rx_addr(rx_addr), .tx_addr(tx_addr), .tmo_cycles(tmo_cycles),
        .dma_rx_address(dma_rx_address), .dma_tx_address(dma_tx_address),
        .dma_rx_start(dma_rx_start), .dma_tx_start(dma_tx_start),
        .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
        .load_en(load_en), .core_start(core_start), .core_done(core_done),
        .res_load(res_load), .status(status)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_cs += int'(core_start);
        n_rl += int'(res_load);
        n_txs += int'(dma_tx_start);
        n_le3 += int'(load_en[3]);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job;
        for (int i = 0; i < N; i++) begin
            slot[i] = $urandom;
            rx_addr[i*32 +: 32] = slot[i];
        end
        tx_addr = $urandom;
        go = 1'b1;
        tick;
        chk("start_idle", 32'(status[1]), 32'd0);
    endtask

    // ev: 0 done, 1 error only, 2 error together with done
    task automatic rx_op(input int op, input int lat, input int ev);
        chk("rx_start", 32'(dma_rx_start), 32'd1);
        chk("rx_addr", dma_rx_address, slot[op]);
        chk("rx_load_req", 32'(load_en), 32'd0);
        dma_idle = 1'b0;
        tick;
        chk("rx_start_off", 32'(dma_rx_start), 32'd0);
        chk("load_en", 32'(load_en), 32'(1) << op);
        repeat (lat - 1) tick;
        dma_done = ev != 1;
        dma_error = ev != 0;
        #1;
        chk("load_en_done", 32'(load_en), 32'(1) << op);
        tick;
        dma_done = 1'b0;
        dma_error = 1'b0;
        dma_idle = 1'b1;
    endtask

    task automatic core_phase(input int clat);
        chk("core_start", 32'(core_start), 32'd1);
        tick;
        chk("core_start_off", 32'(core_start), 32'd0);
        repeat (clat - 1) tick;
        chk("res_early", 32'(res_load), 32'd0);
        core_done = 1'b1;
        #1;
        chk("res_load", 32'(res_load), 32'd1);
        tick;
        chk("res_held", 32'(res_load), 32'd0);
        core_done = 1'b0;
    endtask

    task automatic tx_phase(input int lat);
        chk("tx_start", 32'(dma_tx_start), 32'd1);
        chk("tx_addr", dma_tx_address, tx_addr);
        dma_idle = 1'b0;
        tick;
        chk("tx_start_off", 32'(dma_tx_start), 32'd0);
        repeat (lat - 1) tick;
        dma_done = 1'b1;
        tick;
        dma_done = 1'b0;
        dma_idle = 1'b1;
        chk("done_status", 32'(status[7:0]), 32'h01);
    endtask

    task automatic finish_job;
        repeat ($urandom_range(0, 3)) begin
            tick;
            chk("done_hold", 32'(status[0]), 32'd1);
        end
        go = 1'b0;
        tick;
        chk("back_idle", 32'(status[7:0]), 32'h02);
    endtask

    task automatic job(input int lat, input int clat);
        int cs0, rl0, tx0, le0;
        cs0 = n_cs; rl0 = n_rl; tx0 = n_txs; le0 = n_le3;
        start_job;
        for (int op = 0; op < N; op++) rx_op(op, lat, 0);
        core_phase(clat);
        tx_phase(lat);
        finish_job;
        chk("n_core_start", 32'(n_cs - cs0), 32'd1);
        chk("n_res_load", 32'(n_rl - rl0), 32'd1);
        chk("n_tx_start", 32'(n_txs - tx0), 32'd1);
        chk("n_load3", 32'(n_le3 - le0), 32'(lat));
    endtask

    task automatic dma_err_job(input int op_err, input int ev);
        int cs0, tx0, le0;
        cs0 = n_cs; tx0 = n_txs; le0 = n_le3;
        start_job;
        for (int op = 0; op < op_err; op++) rx_op(op, 2, 0);
        rx_op(op_err, $urandom_range(1, 4), ev);
        chk("err_bit", 32'(status[2]), 32'd1);
        chk("err_code", 32'(status[4:3]), 32'd1);
        chk("err_load", 32'(load_en), 32'd0);
        repeat (5) tick;
        chk("err_stay", 32'(status[2]), 32'd1);
        if (op_err < 3) chk("err_no_load3", 32'(n_le3 - le0), 32'd0);
        chk("err_no_core", 32'(n_cs - cs0), 32'd0);
        chk("err_no_tx", 32'(n_txs - tx0), 32'd0);
        go = 1'b0;
        tick;
        chk("err_to_idle", 32'(status[1]), 32'd1);
    endtask

    initial begin
        int n;
        int rl0;
        repeat (3) tick;
        chk("rst_status", status, 32'h2);
        chk("rst_rx_start", 32'(dma_rx_start), 32'd0);
        chk("rst_tx_start", 32'(dma_tx_start), 32'd0);
        chk("rst_rx_addr", dma_rx_address, 32'd0);
        chk("rst_tx_addr", dma_tx_address, 32'd0);
        chk("rst_load", 32'(load_en), 32'd0);
        chk("rst_core", 32'(core_start), 32'd0);
        resetn = 1'b1;
        tick;

        job(3, 10);
        for (int k = 0; k < 4; k++) begin
            tmo_cycles = $urandom_range(0, 1) ? '0 : TW'(200);
            job($urandom_range(1, 5), $urandom_range(1, 15));
        end
        tmo_cycles = '0;

        dma_err_job(2, 1);
        dma_err_job($urandom_range(0, N - 1), 2);

        tmo_cycles = TW'(100);
        start_job;
        dma_idle = 1'b0;
        tick;
        n = 0;
        while (!status[2] && n < 300) begin
            n++;
            tick;
        end
        chk("dtmo_cycles", 32'(n), 32'd100);
        chk("dtmo_code", 32'(status[4:3]), 32'd2);
        dma_idle = 1'b1;
        go = 1'b0;
        tick;

        tmo_cycles = TW'(50);
        start_job;
        for (int op = 0; op < N; op++) rx_op(op, 2, 0);
        chk("ctmo_start", 32'(core_start), 32'd1);
        tick;
        n = 0;
        while (!status[2] && n < 300) begin
            n++;
            tick;
        end
        chk("ctmo_cycles", 32'(n), 32'd50);
        chk("ctmo_code", 32'(status[4:3]), 32'd3);
        go = 1'b0;
        tick;
        tmo_cycles = '0;
        start_job;
        chk("ctmo_code_clr", 32'(status[4:3]), 32'd0);
        for (int op = 0; op < N; op++) rx_op(op, 3, 0);
        core_phase(500);
        tx_phase(3);
        finish_job;

        tmo_cycles = TW'(4);
        start_job;
        rx_op(0, 4, 0);
        chk("tie_done_tmo", 32'(status[2]), 32'd0);
        for (int op = 1; op < N; op++) rx_op(op, 2, 0);
        core_phase(3);
        tx_phase(2);
        finish_job;
        tmo_cycles = '0;

        rl0 = n_rl;
        start_job;
        for (int op = 0; op < N; op++) rx_op(op, 2, 0);
        tick;
        tick;
        abort = 1'b1;
        tick;
        chk("abort_idle", 32'(status[7:0]), 32'h02);
        chk("abort_res", 32'(res_load), 32'd0);
        chk("abort_core", 32'(core_start), 32'd0);
        abort = 1'b0;
        go = 1'b0;
        tick;
        chk("abort_stay", 32'(status[1]), 32'd1);
        chk("abort_no_res", 32'(n_rl - rl0), 32'd0);

        start_job;
        for (int op = 0; op < 3; op++) rx_op(op, 2, 0);
        dma_idle = 1'b0;
        tick;
        chk("pre_rst_load", 32'(load_en), 32'h8);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_status", status, 32'h2);
        chk("mid_rst_load", 32'(load_en), 32'd0);
        chk("mid_rst_rx_start", 32'(dma_rx_start), 32'd0);
        chk("mid_rst_rx_addr", dma_rx_address, 32'd0);
        chk("mid_rst_tx_addr", dma_tx_address, 32'd0);
        dma_idle = 1'b1;
        go = 1'b0;
        tick;
        resetn = 1'b1;
        tick;
        job(2, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
